// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared codes for the PC-source sequencer and the PC-source mux
// Holds instruction class codes, pc_source select codes, exception cause
// codes, the sequencer FSM state encoding and the pending-cause helper.
package pc_seq_pkg;
   typedef enum logic [2:0] {
      CLS_SEQ  = 3'b000,
      CLS_BEQ  = 3'b001,
      CLS_BNE  = 3'b010,
      CLS_J    = 3'b011,
      CLS_JR   = 3'b100,
      CLS_RTE  = 3'b101,
      CLS_RSV6 = 3'b110,
      CLS_RSV7 = 3'b111
   } cls_t;
   typedef enum logic [2:0] {
      SRC_ALU_RESULT = 3'b000,
      SRC_ALU_OUT    = 3'b001,
      SRC_JUMP       = 3'b010,
      SRC_EPC        = 3'b100,
      SRC_VECTOR     = 3'b110
   } src_t;
   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_OVF  = 2'b01,
      CAUSE_DIV0 = 2'b10,
      CAUSE_ILL  = 2'b11
   } cause_t;
   typedef enum logic [2:0] {
      S_IDLE,
      S_RESOLVE,
      S_EXC_SAVE,
      S_EXC_WAIT,
      S_EXC_LOAD
   } state_t;
   // An explicit exception request outranks the illegal-opcode cause raised
   // by a reserved class.
   function automatic logic [1:0] pend_cause(input logic [1:0] exc, input logic [2:0] cls);
      return exc != CAUSE_NONE ? exc : cls > CLS_RTE ? CAUSE_ILL : CAUSE_NONE;
   endfunction
endpackage

// File: rtl/exc_wait_counter.sv
// exc_wait_counter: loadable down-counter with zero flag for vector-fetch wait states
// Ports: clk, reset (sync, active-high), load (load_val into counter),
//        load_val[W-1:0], zero (counter is 0). Counts down to 0 and holds.
module exc_wait_counter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : zero ? cnt_q : cnt_q - W'(1);
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign zero = cnt_q == '0;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle control-flow sequencer driving the PC-source select
// Ports: clk, reset (sync, active-high); instr_valid, instr_class[2:0],
//        exc_req[1:0] (sampled together in IDLE); zero (ALU flag, used in
//        RESOLVE); pc_source[2:0], pc_write, epc_write, mem_read,
//        exc_cause[1:0], busy, done.
// Optional: define PC_SEQ_STATS_EN to add saturating taken_cnt[15:0] and
//        exc_cnt[15:0] outputs.
// MEM_LAT (0..15) sets the exception-vector read wait cycles.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [2:0]  instr_class,
   input  logic [1:0]  exc_req,
   input  logic        zero,
   output logic [2:0]  pc_source,
   output logic        pc_write,
   output logic        epc_write,
   output logic        mem_read,
   output logic [1:0]  exc_cause,
   output logic        busy,
   output logic        done
`ifdef PC_SEQ_STATS_EN
   ,
   output logic [15:0] taken_cnt,
   output logic [15:0] exc_cnt
`endif
);
   state_t      state_q, state_d;
   logic [2:0]  cls_q, cls_d, src_q, src_d;
   logic [1:0]  pend_q, pend_d, cause_q, cause_d;
   logic        pw_q, pw_d, epc_q, epc_d, mem_q, mem_d, done_q, done_d, busy_q, busy_d;
   logic        cnt_zero, br_take;
   if (MEM_LAT > 0) begin : g_wait
      localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
      exc_wait_counter #(.W(CW)) u_cnt (
         .clk(clk),
         .reset(reset),
         .load(state_q == S_EXC_SAVE),
         .load_val(CW'(MEM_LAT - 1)),
         .zero(cnt_zero)
      );
   end else begin : g_nowait
      assign cnt_zero = 1'b1;
   end
   // Outputs for the next state are decided one cycle early and registered;
   // only the conditional branch write waits for zero in RESOLVE itself.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      pend_d  = pend_q;
      cause_d = cause_q;
      src_d   = SRC_ALU_RESULT;
      pw_d    = 1'b0;
      epc_d   = 1'b0;
      mem_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: if (instr_valid) begin
            state_d = S_RESOLVE;
            cls_d   = instr_class;
            pend_d  = pend_cause(exc_req, instr_class);
            if (pend_d == CAUSE_NONE) begin
               done_d = 1'b1;
               src_d  = instr_class == CLS_BEQ || instr_class == CLS_BNE ? SRC_ALU_OUT :
                        instr_class == CLS_J ? SRC_JUMP :
                        instr_class == CLS_RTE ? SRC_EPC : SRC_ALU_RESULT;
               pw_d   = instr_class == CLS_J || instr_class == CLS_JR || instr_class == CLS_RTE;
            end
         end
         S_RESOLVE: if (pend_q != CAUSE_NONE) begin
            state_d = S_EXC_SAVE;
            cause_d = pend_q;
            epc_d   = 1'b1;
            mem_d   = 1'b1;
         end else begin
            state_d = S_IDLE;
         end
         S_EXC_SAVE: if (MEM_LAT > 0) begin
            state_d = S_EXC_WAIT;
            mem_d   = 1'b1;
         end else begin
            state_d = S_EXC_LOAD;
            src_d   = SRC_VECTOR;
            pw_d    = 1'b1;
            done_d  = 1'b1;
         end
         S_EXC_WAIT: if (cnt_zero) begin
            state_d = S_EXC_LOAD;
            src_d   = SRC_VECTOR;
            pw_d    = 1'b1;
            done_d  = 1'b1;
         end else begin
            mem_d = 1'b1;
         end
         S_EXC_LOAD: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      busy_d = state_d != S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cls_q   <= CLS_SEQ;
         pend_q  <= CAUSE_NONE;
         cause_q <= CAUSE_NONE;
         src_q   <= SRC_ALU_RESULT;
         pw_q    <= 1'b0;
         epc_q   <= 1'b0;
         mem_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         pend_q  <= pend_d;
         cause_q <= cause_d;
         src_q   <= src_d;
         pw_q    <= pw_d;
         epc_q   <= epc_d;
         mem_q   <= mem_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end
   assign br_take = state_q == S_RESOLVE && pend_q == CAUSE_NONE &&
                    (cls_q == CLS_BEQ ? zero : cls_q == CLS_BNE ? ~zero : 1'b0);
   // Strobes are masked while reset is asserted so an interrupted sequence
   // never writes in the reset cycle.
   assign pc_write  = ~reset & (pw_q | br_take);
   assign epc_write = ~reset & epc_q;
   assign done      = ~reset & done_q;
   assign pc_source = src_q;
   assign mem_read  = mem_q;
   assign exc_cause = cause_q;
   assign busy      = busy_q;
`ifdef PC_SEQ_STATS_EN
   logic [15:0] taken_q, taken_d, exc_q, exc_d;
   always_comb begin
      taken_d = state_q == S_RESOLVE && pc_write && ~&taken_q ? taken_q + 16'd1 : taken_q;
      exc_d   = state_q == S_RESOLVE && pend_q != CAUSE_NONE && ~&exc_q ? exc_q + 16'd1 : exc_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         taken_q <= '0;
         exc_q   <= '0;
      end else begin
         taken_q <= taken_d;
         exc_q   <= exc_d;
      end
   end
   assign taken_cnt = taken_q;
   assign exc_cnt   = exc_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized self-checking bench against a per-transaction timeline model
module tb_pc_sequencer;
   localparam int LAT = 2;
   logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, zero = 1'b0;
   logic [2:0] instr_class = 3'd0;
   logic [1:0] exc_req = 2'd0;
   logic [2:0] pc_source;
   logic pc_write, epc_write, mem_read, busy, done;
   logic [1:0] exc_cause;
`ifdef PC_SEQ_STATS_EN
   logic [15:0] taken_cnt, exc_cnt;
`endif
   int vectors = 0, errors = 0;
   int m_taken = 0, m_exc = 0;
   logic [1:0] m_cause = 2'd0;
   logic [9:0] expq[$];
   always #5 clk = ~clk;
   pc_sequencer #(.MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_class(instr_class),
      .exc_req(exc_req), .zero(zero), .pc_source(pc_source), .pc_write(pc_write),
      .epc_write(epc_write), .mem_read(mem_read), .exc_cause(exc_cause), .busy(busy),
      .done(done)
`ifdef PC_SEQ_STATS_EN
      , .taken_cnt(taken_cnt), .exc_cnt(exc_cnt)
`endif
   );
   function automatic logic [9:0] obs();
      return {pc_source, pc_write, epc_write, mem_read, exc_cause, busy, done};
   endfunction
   function automatic logic [9:0] ev(int src, int pw, int epc, int mem, logic [1:0] c, int b, int d);
      return {3'(src), 1'(pw), 1'(epc), 1'(mem), c, 1'(b), 1'(d)};
   endfunction
   // Expected per-cycle outputs: index 0 is the idle cycle carrying instr_valid,
   // index 1 the cycle after it, and so on up to the done cycle.
   function automatic void model(input logic [2:0] cls, input logic [1:0] exc, input bit zr);
      logic [1:0] cause;
      int src, pw;
      cause = exc != 2'd0 ? exc : (cls >= 3'd6 ? 2'd3 : 2'd0);
      expq = {};
      expq.push_back(ev(0, 0, 0, 0, m_cause, 0, 0));
      if (cause == 2'd0) begin
         src = (cls == 3'd1 || cls == 3'd2) ? 1 : cls == 3'd3 ? 2 : cls == 3'd5 ? 4 : 0;
         pw  = cls == 3'd1 ? int'(zr) : cls == 3'd2 ? int'(!zr) : int'(cls inside {3'd3, 3'd4, 3'd5});
         expq.push_back(ev(src, pw, 0, 0, m_cause, 1, 1));
         if (m_taken < 65535) m_taken += pw;
      end else begin
         expq.push_back(ev(0, 0, 0, 0, m_cause, 1, 0));
         m_cause = cause;
         if (m_exc < 65535) m_exc++;
         expq.push_back(ev(0, 0, 1, 1, m_cause, 1, 0));
         for (int i = 0; i < LAT; i++) expq.push_back(ev(0, 0, 0, 1, m_cause, 1, 0));
         expq.push_back(ev(6, 1, 0, 0, m_cause, 1, 1));
      end
   endfunction
   task automatic drive(input bit iv, input logic [2:0] c, input logic [1:0] e, input bit z);
      @(negedge clk);
      instr_valid = iv;
      instr_class = c;
      exc_req = e;
      zero = z;
      #1;
   endtask
   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'($urandom), 2'($urandom), 1'($urandom));
         vectors++;
         if (obs() !== 10'd0) begin errors++; $display("FAIL reset cyc%0d got %b want %b", k, obs(), 10'd0); end
      end
`ifdef PC_SEQ_STATS_EN
      vectors++;
      if ({taken_cnt, exc_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", {taken_cnt, exc_cnt}); end
`endif
      instr_valid = 1'b0;
      reset = 1'b0;
   endtask
   task automatic test_branch();
      logic [2:0] c;
      bit z;
      for (int t = 0; t < 10; t++) begin
         c = t < 2 ? 3'd1 : t < 4 ? 3'd2 : 3'($urandom_range(0, 2));
         z = t < 4 ? (t[0] == 1'b0) : 1'($urandom);
         model(c, 2'd0, z);
         foreach (expq[k]) begin
            drive(k == 0, c, 2'd0, k == 1 ? z : 1'($urandom));
            vectors++;
            if (obs() !== expq[k]) begin errors++; $display("FAIL branch t%0d cyc%0d got %b want %b", t, k, obs(), expq[k]); end
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [2:0] seq[4] = '{3'd3, 3'd5, 3'd4, 3'd3};
      foreach (seq[t]) begin
         model(seq[t], 2'd0, 1'b0);
         foreach (expq[k]) begin
            drive(k == 0, seq[t], 2'd0, 1'($urandom));
            vectors++;
            if (obs() !== expq[k]) begin errors++; $display("FAIL b2b t%0d cyc%0d got %b want %b", t, k, obs(), expq[k]); end
         end
      end
   endtask
   task automatic test_exception();
      model(3'd1, 2'd1, 1'b1);
      foreach (expq[k]) begin
         drive(k == 0, 3'd1, 2'd1, 1'b1);
         vectors++;
         if (obs() !== expq[k]) begin errors++; $display("FAIL exc_ovf cyc%0d got %b want %b", k, obs(), expq[k]); end
      end
   endtask
   task automatic test_reserved();
      logic [4:0] cases[3] = '{{3'd7, 2'd0}, {3'd7, 2'd2}, {3'd6, 2'd0}};
      foreach (cases[t]) begin
         model(cases[t][4:2], cases[t][1:0], 1'b1);
         foreach (expq[k]) begin
            drive(k == 0, cases[t][4:2], cases[t][1:0], 1'($urandom));
            vectors++;
            if (obs() !== expq[k]) begin errors++; $display("FAIL reserved t%0d cyc%0d got %b want %b", t, k, obs(), expq[k]); end
         end
      end
   endtask
   task automatic test_reset_mid();
      model(3'd1, 2'd1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(k == 0, 3'd1, 2'd1, 1'b0);
         vectors++;
         if (obs() !== expq[k]) begin errors++; $display("FAIL rst_mid cyc%0d got %b want %b", k, obs(), expq[k]); end
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if ({pc_write, epc_write, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_strobe got %b want 000", {pc_write, epc_write, done}); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      m_cause = 2'd0;
      m_taken = 0;
      m_exc = 0;
      vectors++;
      if (obs() !== 10'd0) begin errors++; $display("FAIL rst_mid_idle got %b want %b", obs(), 10'd0); end
      model(3'd0, 2'd0, 1'b0);
      foreach (expq[k]) begin
         drive(k == 0, 3'd0, 2'd0, 1'($urandom));
         vectors++;
         if (obs() !== expq[k]) begin errors++; $display("FAIL rst_mid_seq cyc%0d got %b want %b", k, obs(), expq[k]); end
      end
   endtask
   task automatic test_ignore_pulse();
      model(3'd0, 2'd1, 1'b0);
      foreach (expq[k]) begin
         drive(k == 0 || k == 3, k == 3 ? 3'd3 : 3'd0, k == 3 ? 2'd0 : 2'd1, 1'($urandom));
         vectors++;
         if (obs() !== expq[k]) begin errors++; $display("FAIL ignore cyc%0d got %b want %b", k, obs(), expq[k]); end
      end
`ifdef PC_SEQ_STATS_EN
      vectors++;
      if (exc_cnt !== 16'd1 || taken_cnt !== 16'(m_taken)) begin
         errors++; $display("FAIL ignore_cnt got exc=%0d taken=%0d want exc=1 taken=%0d", exc_cnt, taken_cnt, m_taken);
      end
`endif
   endtask
   task automatic test_random();
      logic [2:0] c;
      logic [1:0] e;
      int p;
      for (int t = 0; t < 40; t++) begin
         c = 3'($urandom);
         e = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'd0;
         model(c, e, 1'($urandom));
         p = expq.size() > 2 ? $urandom_range(1, expq.size() - 2) : 0;
         foreach (expq[k]) begin
            drive(k == 0 || (k != 0 && k == p), c, e, k == 1 ? expq[1][6] ^ (c == 3'd2) : 1'($urandom));
            vectors++;
            if (obs() !== expq[k]) begin errors++; $display("FAIL random t%0d cyc%0d got %b want %b", t, k, obs(), expq[k]); end
         end
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_branch();
      test_back_to_back();
      test_exception();
      test_reserved();
      test_reset_mid();
      test_ignore_pulse();
      test_random();
      drive(1'b0, 3'd0, 2'd0, 1'b0);
      vectors++;
      if (obs() !== ev(0, 0, 0, 0, m_cause, 0, 0)) begin errors++; $display("FAIL final_idle got %b want %b", obs(), ev(0, 0, 0, 0, m_cause, 0, 0)); end
`ifdef PC_SEQ_STATS_EN
      vectors++;
      if (taken_cnt !== 16'(m_taken) || exc_cnt !== 16'(m_exc)) begin
         errors++; $display("FAIL final_cnt got taken=%0d exc=%0d want taken=%0d exc=%0d", taken_cnt, exc_cnt, m_taken, m_exc);
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
